// File: rtl/thiele_logic_bridge.sv
// thiele_logic_bridge: turns a level-held CPU logic query into a single
// valid/ready request to a solver. The bridge waits for the solver response
// and returns it to the CPU as a one-cycle acknowledge.
//
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   logic_req, logic_addr         CPU query; logic_req stays high until logic_ack
//   logic_ack, logic_data         one-cycle completion pulse; result is held afterwards
//   sol_req_valid/ready/addr      request channel to the solver
//   sol_rsp_valid, sol_rsp_data   solver response strobe and payload
//   busy                          high whenever the bridge is not idle
//   err_timeout                   sticky flag, set when a query times out
//   req_count                     wrapping count of completed CPU queries
//
// Optional build macro:
//   THIELE_LOGIC_TIMEOUT_EN  abandons a query after TIMEOUT_CYCLES cycles in
//                            ISSUE/WAIT and returns 32'hFFFFFFFF. Without this
//                            macro the bridge waits indefinitely and
//                            err_timeout is tied to 0.
module thiele_logic_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        logic_req,
  input  logic [31:0] logic_addr,
  output logic        logic_ack,
  output logic [31:0] logic_data,
  output logic        sol_req_valid,
  input  logic        sol_req_ready,
  output logic [31:0] sol_req_addr,
  input  logic        sol_rsp_valid,
  input  logic [31:0] sol_rsp_data,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] req_count
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  // Reject out-of-range timeout settings at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("thiele_logic_bridge: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_set_c;
  logic          tmo_hit_c;

`ifdef THIELE_LOGIC_TIMEOUT_EN
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;

  // The counter holds the number of completed ISSUE/WAIT cycles, so the
  // TIMEOUT_CYCLES-th such cycle is the one that gives up.
  assign tmo_hit_c = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Timeout counter and sticky error flag.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q | err_set_c;
    if (state_q == S_IDLE && logic_req) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_hit_c   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    count_d   = count_q;
    err_set_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (logic_req) begin
          addr_d  = logic_addr;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tmo_hit_c) begin
          valid_d   = 1'b0;
          data_d    = '1;
          err_set_c = 1'b1;
          state_d   = S_ACK;
        end else if (valid_q && sol_req_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (sol_rsp_valid) begin
          data_d  = sol_rsp_data;
          state_d = S_ACK;
        end else if (tmo_hit_c) begin
          data_d    = '1;
          err_set_c = 1'b1;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Wait for the CPU to drop its request so one request gets one ack.
        if (!logic_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // The ack pulse and the count update land in the single ACK cycle.
    ack_d = (state_d == S_ACK) && (state_q != S_ACK);
    if (ack_d) begin
      count_d = count_q + CW'(1);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign logic_ack     = ack_q;
  assign logic_data    = data_q;
  assign sol_req_valid = valid_q;
  assign sol_req_addr  = addr_q;
  assign busy          = busy_q;
  assign req_count     = count_q;

endmodule

// File: tb/tb_thiele_logic_bridge.sv
// Self-checking bench for thiele_logic_bridge. The stimulus pushes each
// expected completion into a queue. A separate monitor pops from the queue
// and compares on every logic_ack. The bench is built with
// THIELE_LOGIC_TIMEOUT_EN either defined or undefined, and it adapts to
// both builds.
module tb_thiele_logic_bridge;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        logic_req;
  logic [31:0] logic_addr;
  logic        logic_ack;
  logic [31:0] logic_data;
  logic        sol_req_valid;
  logic        sol_req_ready;
  logic [31:0] sol_req_addr;
  logic        sol_rsp_valid;
  logic [31:0] sol_rsp_data;
  logic        busy;
  logic        err_timeout;
  logic [15:0] req_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [15:0] model_cnt = 16'h0;
  logic        model_err = 1'b0;

  thiele_logic_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .logic_req    (logic_req),
    .logic_addr   (logic_addr),
    .logic_ack    (logic_ack),
    .logic_data   (logic_data),
    .sol_req_valid(sol_req_valid),
    .sol_req_ready(sol_req_ready),
    .sol_req_addr (sol_req_addr),
    .sol_rsp_valid(sol_rsp_valid),
    .sol_rsp_data (sol_rsp_data),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .req_count    (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] data, input logic tmo);
    model_cnt = model_cnt + 16'd1;
    if (tmo) model_err = 1'b1;
    exp_q.push_back('{data: data, cnt: model_cnt, err: model_err});
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (logic_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(logic_data), 32'h0);
        chk("unexpected_ack_present", 32'(logic_ack), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_data", logic_data, e.data);
        chk("ack_req_count", 32'(req_count), 32'(e.cnt));
        chk("ack_err_timeout", 32'(err_timeout), 32'(e.err));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   32'(logic_ack), 32'h0);
    chk({tag, "_data"},  logic_data, 32'h0);
    chk({tag, "_valid"}, 32'(sol_req_valid), 32'h0);
    chk({tag, "_addr"},  sol_req_addr, 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_err"},   32'(err_timeout), 32'h0);
    chk({tag, "_count"}, 32'(req_count), 32'h0);
  endtask

  // Runs one transaction with the solver always ready and a response in the first WAIT cycle.
  task automatic txn(input logic [31:0] addr, input logic [31:0] data);
    logic_req = 1'b1; logic_addr = addr; sol_req_ready = 1'b1;
    step();
    step();
    sol_rsp_valid = 1'b1; sol_rsp_data = data; push_exp(data, 1'b0);
    step();
    sol_rsp_valid = 1'b0; logic_req = 1'b0;
    step();
    step();
    chk("txn_idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; logic_req = 1'b0; logic_addr = 32'h0;
    sol_req_ready = 1'b0; sol_rsp_valid = 1'b0; sol_rsp_data = 32'h0;
    step(); step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // Basic query: response arrives two cycles after the handshake.
    logic_req = 1'b1; logic_addr = 32'h10; sol_req_ready = 1'b1;
    step();
    chk("basic_valid_c1", 32'(sol_req_valid), 32'h1);
    chk("basic_addr", sol_req_addr, 32'h10);
    chk("basic_busy", 32'(busy), 32'h1);
    step();
    chk("basic_valid_drop", 32'(sol_req_valid), 32'h0);
    step();
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'hABCD1234; push_exp(32'hABCD1234, 1'b0);
    step();
    chk("basic_ack_latency", 32'(logic_ack), 32'h1);
    sol_rsp_valid = 1'b0;
    step();
    chk("basic_ack_single", 32'(logic_ack), 32'h0);
    chk("basic_data_held", logic_data, 32'hABCD1234);
    logic_req = 1'b0;
    step(); step();

    // Backpressure: ready low for 5 cycles. A changed logic_addr must not be captured.
    logic_req = 1'b1; logic_addr = 32'h2000_0004; sol_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_valid_held", 32'(sol_req_valid), 32'h1);
      chk("bp_addr_stable", sol_req_addr, 32'h2000_0004);
      if (i == 0) logic_addr = 32'hFFFF_0000;
      if (i == 5) sol_req_ready = 1'b1;
    end
    step();
    chk("bp_valid_drop", 32'(sol_req_valid), 32'h0);
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'h5555AAAA; push_exp(32'h5555AAAA, 1'b0);
    step();
    sol_rsp_valid = 1'b0; logic_req = 1'b0;
    step(); step();

    // Held request: stays high for 20 cycles after the ack.
    logic_req = 1'b1; logic_addr = 32'h30; sol_req_ready = 1'b1;
    step(); step();
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'h0000_0030; push_exp(32'h0000_0030, 1'b0);
    step();
    sol_rsp_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_no_reissue", 32'(sol_req_valid), 32'h0);
      chk("held_busy", 32'(busy), 32'h1);
    end
    logic_req = 1'b0;
    step(); step();
    chk("held_release_idle", 32'(busy), 32'h0);
    txn(32'h34, 32'h1234_0034);

    // Stray responses while idle are ignored.
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'hDEAD_BEEF;
    step(); step();
    sol_rsp_valid = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'h0);
    chk("stray_idle_data", logic_data, 32'h1234_0034);

    // Reset in the middle of WAIT, then a response to the abandoned request.
    logic_req = 1'b1; logic_addr = 32'h44; sol_req_ready = 1'b1;
    step(); step();
    chk("midrst_in_wait", 32'(busy), 32'h1);
    rst_n = 1'b0; logic_req = 1'b0;
    step();
    chk_reset_vals("midrst");
    rst_n = 1'b1; model_cnt = 16'h0; model_err = 1'b0;
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'h0BAD_0BAD;
    step(); step();
    sol_rsp_valid = 1'b0;
    chk("midrst_stray_busy", 32'(busy), 32'h0);
    chk("midrst_stray_data", logic_data, 32'h0);

    // Counter wrap: preload 0xFFFF completions.
    force dut.count_q = 16'hFFFF;
    step(); step();
    release dut.count_q;
    step();
    chk("wrap_preload", 32'(req_count), 32'h0000FFFF);
    model_cnt = 16'hFFFF;
    txn(32'h50, 32'hCAFE_0050);
    chk("wrap_count", 32'(req_count), 32'h0);

`ifdef THIELE_LOGIC_TIMEOUT_EN
    // A response in the timeout cycle wins, and err_timeout stays clear.
    logic_req = 1'b1; logic_addr = 32'h60; sol_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'h0000_0060; push_exp(32'h0000_0060, 1'b0);
    step();
    sol_rsp_valid = 1'b0; logic_req = 1'b0;
    chk("tie_err_clear", 32'(err_timeout), 32'h0);
    step(); step();

    // Timeout: the solver never responds, so the ack arrives in cycle 9.
    logic_req = 1'b1; logic_addr = 32'h70; sol_req_ready = 1'b1;
    push_exp(32'hFFFF_FFFF, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("tmo_no_early_ack", 32'(logic_ack), 32'h0);
    end
    step();
    chk("tmo_ack_cycle9", 32'(logic_ack), 32'h1);
    logic_req = 1'b0;
    step(); step();
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'h1A7E_0070;
    step();
    sol_rsp_valid = 1'b0;
    step();
    chk("tmo_late_rsp_data", logic_data, 32'hFFFF_FFFF);
    chk("tmo_err_sticky", 32'(err_timeout), 32'h1);
`else
    // Without the timeout build, a silent solver leaves the bridge waiting.
    logic_req = 1'b1; logic_addr = 32'h70; sol_req_ready = 1'b1;
    for (int i = 0; i < 80; i++) step();
    chk("notmo_still_busy", 32'(busy), 32'h1);
    chk("notmo_err_zero", 32'(err_timeout), 32'h0);
    sol_rsp_valid = 1'b1; sol_rsp_data = 32'h0000_0070; push_exp(32'h0000_0070, 1'b0);
    step();
    sol_rsp_valid = 1'b0; logic_req = 1'b0;
    step(); step();
`endif

    step(); step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
